// File: rtl/hbm_arb_pkg.sv
// Shared types and helpers for the HBM pseudo-channel arbiter.
//   state_t        : arbiter FSM state (IDLE waiting to arbitrate, LOCK owning the port)
//   HBM_ADDR_W     : default HBM byte address width
//   HBM_DATA_W     : default beat width
//   HBM_ALIGN_BITS : default number of address LSBs that must be zero
//   aligned()      : 1 when the low align_bits of addr are all zero
package hbm_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam int HBM_ADDR_W     = 34;
  localparam int HBM_DATA_W     = 256;
  localparam int HBM_ALIGN_BITS = 5;

  // Takes a 64-bit view of the address so one function serves any ADDR_W up to 64.
  function automatic logic aligned(input logic [63:0] addr,
                                   input int          align_bits = HBM_ALIGN_BITS);
    logic [63:0] mask;
    mask = (64'd1 << align_bits) - 64'd1;
    return (addr & mask) == 64'd0;
  endfunction

endpackage

// File: rtl/hbm_rr_pick.sv
// Combinational rotate-priority picker.
//   req        in  NUM_REQ          request vector
//   last_grant in  $clog2(NUM_REQ)  most recently granted index
//   idx        out $clog2(NUM_REQ)  first requester at or after last_grant+1 (mod NUM_REQ)
//   any        out 1                at least one request present
module hbm_rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       any
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] cand;

  // Walk from the farthest candidate back to the nearest so the nearest
  // requester after last_grant is the one left in idx.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hbm_pc_arbiter.sv
// Round-robin arbiter sharing one HBM pseudo-channel command port among
// NUM_REQ requesters. A grant lasts until the requester's last beat or
// MAX_HOLD accepted beats. Accepted beats land in a one-deep output register
// that drains on cmd_ready independently of arbitration.
//   AXI_ACLK / AXI_ARESET        clock, synchronous active-high reset
//   req_valid/ready/is_write/last per-requester beat handshake and type
//   req_address / req_data       packed per-requester address and write data
//   cmd_ready                    downstream accepts the presented beat
//   write_enable/address/data    write beat presented downstream
//   read_enable/address          read beat presented downstream
//   grant_id                     current/last granted requester
//   align_err                    one-cycle pulse when a misaligned beat is dropped
module hbm_pc_arbiter
  import hbm_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_W     = HBM_ADDR_W,
  parameter int DATA_W     = HBM_DATA_W,
  parameter int MAX_HOLD   = 16,
  parameter int ALIGN_BITS = HBM_ALIGN_BITS
) (
  input  logic                       AXI_ACLK,
  input  logic                       AXI_ARESET,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         req_is_write,
  input  logic [NUM_REQ-1:0]         req_last,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_address,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic                       cmd_ready,
  output logic                       write_enable,
  output logic [ADDR_W-1:0]          write_address,
  output logic [DATA_W-1:0]          write_data,
  output logic                       read_enable,
  output logic [ADDR_W-1:0]          read_address,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       align_err
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  last_grant_q, last_grant_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              wen_q, wen_d;
  logic              ren_q, ren_d;
  logic              aerr_q, aerr_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;

  logic [ADDR_W-1:0] addr_arr [NUM_REQ];
  logic [DATA_W-1:0] data_arr [NUM_REQ];

  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;

  logic              sel_valid, sel_wr, sel_last, sel_ok;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              out_busy, lock_ready, beat_acc;
  logic [HOLD_W-1:0] hold_nxt;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i] = req_address[i*ADDR_W +: ADDR_W];
      data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  hbm_rr_pick #(
    .NUM_REQ    (NUM_REQ)
  ) u_pick (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .idx        (pick_idx),
    .any        (pick_any)
  );

  assign sel_valid  = req_valid[grant_q];
  assign sel_wr     = req_is_write[grant_q];
  assign sel_last   = req_last[grant_q];
  assign sel_addr   = addr_arr[grant_q];
  assign sel_data   = data_arr[grant_q];
  assign sel_ok     = aligned(64'(sel_addr), ALIGN_BITS);

  // The output register can take a new beat when empty or being emptied this cycle.
  assign out_busy   = wen_q | ren_q;
  assign lock_ready = ~out_busy | cmd_ready;
  assign beat_acc   = (state_q == LOCK) & sel_valid & lock_ready;
  assign hold_nxt   = hold_cnt_q + HOLD_W'(1);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    hold_cnt_d   = hold_cnt_q;
    req_ready    = '0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d      = pick_idx;
          last_grant_d = pick_idx;
          hold_cnt_d   = '0;
          state_d      = LOCK;
        end
      end
      LOCK: begin
        req_ready[grant_q] = lock_ready;
        // Misaligned beats still consume hold budget and can carry last.
        if (beat_acc) begin
          if (sel_last || (hold_nxt == HOLD_W'(MAX_HOLD))) begin
            state_d    = IDLE;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_nxt;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wen_d   = wen_q;
    ren_d   = ren_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    raddr_d = raddr_q;
    aerr_d  = 1'b0;
    if (beat_acc) begin
      wen_d  = sel_ok & sel_wr;
      ren_d  = sel_ok & ~sel_wr;
      aerr_d = ~sel_ok;
      if (sel_ok && sel_wr) begin
        waddr_d = sel_addr;
        wdata_d = sel_data;
      end
      if (sel_ok && !sel_wr) begin
        raddr_d = sel_addr;
      end
    end else if (cmd_ready) begin
      wen_d = 1'b0;
      ren_d = 1'b0;
    end
  end

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      hold_cnt_q   <= '0;
      wen_q        <= 1'b0;
      ren_q        <= 1'b0;
      aerr_q       <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      raddr_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      hold_cnt_q   <= hold_cnt_d;
      wen_q        <= wen_d;
      ren_q        <= ren_d;
      aerr_q       <= aerr_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      raddr_q      <= raddr_d;
    end
  end

  assign write_enable  = wen_q;
  assign read_enable   = ren_q;
  assign write_address = waddr_q;
  assign write_data    = wdata_q;
  assign read_address  = raddr_q;
  assign grant_id      = grant_q;
  assign align_err     = aerr_q;

endmodule
